lut_neuron_table_writer: RTL and testbench
==========================================

// Module: lut_neuron_table_writer
// PURPOSE
//  Runtime-programmable LUT neuron: the write side of a fixed-ROM LUT neuron. A config stream
//  writes every truth-table entry (2**IN_BITS words of OUT_BITS) into a distributed-RAM table;
//  once armed, the table answers lookups exactly as a synthesized ROM neuron does.
//  Lets the autoencoder layers be reloaded with new trained tables without resynthesis.
// PARAMETERS
//  IN_BITS   8  lookup address width (packed concatenation of quantized neuron inputs)
//  OUT_BITS  2  table word width (quantized neuron output)
//  DEPTH     2**IN_BITS  localparam, not overridable
// PORTS
//  clk         in   1         clock; all logic on rising edge
//  rst         in   1         reset, synchronous, active-low
//  cfg_start   in   1         1-cycle pulse: begin (re)load at address 0
//  cfg_valid   in   1         config word valid
//  cfg_ready   out  1         config word accepted when cfg_valid&&cfg_ready
//  cfg_data    in   OUT_BITS  table word for current write address
//  cfg_done    out  1         level: table fully loaded, lookups enabled
//  cfg_err     out  1         sticky: cfg_valid in non-LOAD state; cleared by cfg_start or reset
//  M0          in   IN_BITS   lookup address
//  in_valid    in   1         lookup request valid
//  in_ready    out  1         lookup accepted when in_valid&&in_ready
//  M1          out  OUT_BITS  lookup result
//  out_valid   out  1         M1 valid
//  out_ready   in   1         downstream accepts M1
// BEHAVIOUR
//  Reset (rst==0 at edge): state=EMPTY, wr_addr=0, cfg_ready=0, cfg_done=0, cfg_err=0,
//   in_ready=0, out_valid=0, M1=0. Table contents are NOT cleared (undefined until loaded).
//  States: EMPTY -> LOAD on cfg_start; LOAD -> ARMED when word DEPTH-1 accepted;
//   ARMED -> LOAD on cfg_start. cfg_start in LOAD restarts at wr_addr=0 (partial load dropped).
//  LOAD: cfg_ready=1; each handshake writes table[wr_addr]<=cfg_data, wr_addr++.
//   wr_addr is IN_BITS+1 wide; terminal test is wr_addr==DEPTH-1 on handshake, then wr_addr->0.
//  cfg_done=1 only in ARMED; drops the cycle after cfg_start.
//  cfg_start has priority over a same-cycle cfg handshake: that word is discarded.
//  cfg_valid while EMPTY/ARMED (without cfg_start same cycle) sets cfg_err; no write occurs.
//  Lookup: in_ready = ARMED && (!out_valid || out_ready). Accepted request registers
//   M1<=table[M0], out_valid<=1 next cycle (latency 1). Held stable while out_valid&&!out_ready.
//   out_valid clears when out_ready and no new request accepted.
//  Leaving ARMED (cfg_start): in_ready drops next cycle; a pending out_valid result is kept
//   until consumed (it reflects the old table). No lookup is accepted in LOAD.
//  Write and read ports are independent; no read/write collision exists since reads only in ARMED.
//  Full throughput: one lookup/cycle with out_ready held 1; one config word/cycle.
// STRUCTURE
//  Shared package lut_neuron_pkg: state enum {EMPTY,LOAD,ARMED}, default IN_BITS/OUT_BITS.
//  One sub-module: lut_neuron_ram (DEPTH x OUT_BITS, 1 sync write port, 1 async read port,
//   rom_style/ram_style distributed). Control FSM, counter, output register in top.
// TESTING
//  1 Reset then in_valid=1, M0=8'h00 -> in_ready=0, out_valid=0, M1=2'b00 for 10 cycles.
//  2 cfg_start, stream 256 words data=addr[1:0] back-to-back -> cfg_done=1 exactly 1 cycle after
//    word 255; lookups M0=8'hC5,8'h02,8'hFF -> M1=2'b01,2'b10,2'b11, each 1 cycle after accept.
//  3 Armed, out_ready=0 for 5 cycles after one request M0=8'h03 -> M1=2'b11 held, in_ready=0;
//    out_ready=1 -> next request accepted same cycle.
//  4 Load 100 words, pulse cfg_start, load full table of 2'b10 -> every M0 of 256 returns 2'b10.
//  5 Armed, cfg_valid=1 without cfg_start -> cfg_err=1 next cycle, table unchanged; cfg_start
//    clears cfg_err.
//  6 rst low mid-load (word 40) -> all outputs reset values; cfg_done stays 0 until fresh load.

Source files
------------

// File: rtl/lut_neuron_pkg.sv
// Shared types and defaults for the runtime-programmable LUT neuron.
package lut_neuron_pkg;

    localparam int IN_BITS_DEF  = 8;
    localparam int OUT_BITS_DEF = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        LOAD  = 2'd1,
        ARMED = 2'd2
    } state_t;

endpackage

// File: rtl/lut_neuron_ram.sv
// Distributed-RAM truth table: one synchronous write port, one asynchronous read port.
module lut_neuron_ram
    import lut_neuron_pkg::*;
#(
    parameter int ADDR_BITS = IN_BITS_DEF,
    parameter int DATA_BITS = OUT_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [DATA_BITS-1:0] wdata,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [DATA_BITS-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    (* ram_style = "distributed", rom_style = "distributed" *)
    logic [DATA_BITS-1:0] mem_r [0:DEPTH-1];

    // Table write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/lut_neuron_table_writer.sv
// LUT neuron with a config-stream loaded truth table; lookups are served only once the table is complete.
module lut_neuron_table_writer
    import lut_neuron_pkg::*;
#(
    parameter int IN_BITS  = IN_BITS_DEF,
    parameter int OUT_BITS = OUT_BITS_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_start,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [OUT_BITS-1:0] cfg_data,
    output logic                cfg_done,
    output logic                cfg_err,
    input  logic [IN_BITS-1:0]  M0,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [OUT_BITS-1:0] M1,
    output logic                out_valid,
    input  logic                out_ready
);

    localparam int               DEPTH     = 2 ** IN_BITS;
    localparam logic [IN_BITS:0] LAST_ADDR = (IN_BITS + 1)'(DEPTH - 1);
    localparam logic [IN_BITS:0] ADDR_ONE  = {{IN_BITS{1'b0}}, 1'b1};

    state_t               state_r;
    state_t               state_nxt_s;
    logic [IN_BITS:0]     wr_addr_r;
    logic                 cfg_err_r;
    logic                 out_valid_r;
    logic [OUT_BITS-1:0]  m1_r;
    logic [OUT_BITS-1:0]  rd_data_s;
    logic                 wr_en_s;
    logic                 wr_last_s;
    logic                 cfg_stray_s;
    logic                 lookup_s;

    // Handshake qualifiers; cfg_start overrides a same-cycle config word.
    always_comb begin
        wr_en_s     = (state_r == LOAD) && cfg_valid && !cfg_start;
        wr_last_s   = wr_en_s && (wr_addr_r == LAST_ADDR);
        cfg_stray_s = cfg_valid && !cfg_start && (state_r != LOAD);
        lookup_s    = in_valid && in_ready;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= EMPTY;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            EMPTY: begin
                if (cfg_start) state_nxt_s = LOAD;
                else           state_nxt_s = EMPTY;
            end
            LOAD: begin
                if (cfg_start)      state_nxt_s = LOAD;
                else if (wr_last_s) state_nxt_s = ARMED;
                else                state_nxt_s = LOAD;
            end
            ARMED: begin
                if (cfg_start) state_nxt_s = LOAD;
                else           state_nxt_s = ARMED;
            end
            default: state_nxt_s = EMPTY;
        endcase
    end

    // FSM output decode; in_ready also depends on output-stage backpressure.
    always_comb begin
        cfg_ready = 1'b0;
        cfg_done  = 1'b0;
        in_ready  = 1'b0;
        case (state_r)
            LOAD: begin
                cfg_ready = 1'b1;
            end
            ARMED: begin
                cfg_done = 1'b1;
                in_ready = !out_valid_r || out_ready;
            end
            default: begin
                cfg_ready = 1'b0;
            end
        endcase
    end

    // Write address counter, wraps to 0 after the last table word.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_addr_r <= '0;
        end else if (cfg_start || wr_last_s) begin
            wr_addr_r <= '0;
        end else if (wr_en_s) begin
            wr_addr_r <= wr_addr_r + ADDR_ONE;
        end
    end

    // Sticky error for config words offered outside a load.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cfg_err_r <= 1'b0;
        end else if (cfg_start) begin
            cfg_err_r <= 1'b0;
        end else if (cfg_stray_s) begin
            cfg_err_r <= 1'b1;
        end
    end

    // Lookup output register; a pending result outlives a reload until consumed.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid_r <= 1'b0;
            m1_r        <= '0;
        end else if (lookup_s) begin
            out_valid_r <= 1'b1;
            m1_r        <= rd_data_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign cfg_err   = cfg_err_r;
    assign out_valid = out_valid_r;
    assign M1        = m1_r;

    lut_neuron_ram #(
        .ADDR_BITS (IN_BITS),
        .DATA_BITS (OUT_BITS)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en_s),
        .waddr (wr_addr_r[IN_BITS-1:0]),
        .wdata (cfg_data),
        .raddr (M0),
        .rdata (rd_data_s)
    );

endmodule

// File: tb/tb_lut_neuron_table_writer.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural table model.
module tb_lut_neuron_table_writer;

    localparam int M_EMPTY = 0;
    localparam int M_LOAD  = 1;
    localparam int M_ARMED = 2;

    logic       clk;
    logic       rst;
    logic       cfg_start;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_data;
    logic       cfg_done;
    logic       cfg_err;
    logic [7:0] M0;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] M1;
    logic       out_valid;
    logic       out_ready;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Behavioural model state
    int         m_mode = M_EMPTY;
    int         m_widx = 0;
    bit         m_err  = 1'b0;
    bit         m_ov   = 1'b0;
    logic [1:0] m_m1   = 2'b00;
    logic [1:0] tbl [256];

    lut_neuron_table_writer dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_start (cfg_start),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_data  (cfg_data),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err),
        .M0        (M0),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .M1        (M1),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: applies the table-writer rules to the inputs seen at each rising edge.
    initial begin
        bit ir;
        bit acc;
        for (int i = 0; i < 256; i++) tbl[i] = 2'b00;
        forever begin
            @(posedge clk);
            ir = (m_mode == M_ARMED) && (!m_ov || out_ready);
            if (!rst) begin
                m_mode = M_EMPTY;
                m_widx = 0;
                m_err  = 1'b0;
                m_ov   = 1'b0;
                m_m1   = 2'b00;
            end else begin
                acc = in_valid && ir;
                if (acc) begin
                    m_m1 = tbl[M0];
                    m_ov = 1'b1;
                end else if (out_ready) begin
                    m_ov = 1'b0;
                end
                if (cfg_start) begin
                    m_mode = M_LOAD;
                    m_widx = 0;
                    m_err  = 1'b0;
                end else if (cfg_valid && m_mode == M_LOAD) begin
                    tbl[m_widx] = cfg_data;
                    if (m_widx == 255) begin
                        m_mode = M_ARMED;
                        m_widx = 0;
                    end else begin
                        m_widx++;
                    end
                end else if (cfg_valid) begin
                    m_err = 1'b1;
                end
            end
        end
    end

    // Compare: every output against the model on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("cfg_ready", cfg_ready, m_mode == M_LOAD);
                check("cfg_done",  cfg_done,  m_mode == M_ARMED);
                check("cfg_err",   cfg_err,   m_err);
                check("in_ready",  in_ready,  (m_mode == M_ARMED) && (!m_ov || out_ready));
                check("out_valid", out_valid, m_ov);
                check("M1",        M1,        m_m1);
            end
        end
    end

    task automatic lookup(input logic [7:0] a, input logic [1:0] e, input string nm);
        int w;
        w         = 0;
        M0        = a;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        while (!in_ready && w < 20) begin
            tick();
            w++;
        end
        if (w >= 20) begin
            check({nm, "_accept_timeout"}, 32'd0, 32'd1);
        end
        tick();
        in_valid = 1'b0;
        check(nm, M1, e);
        check({nm, "_valid"}, out_valid, 1'b1);
    endtask

    task automatic pulse_start();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_data = 2'b00;
        M0 = 8'h00; in_valid = 1'b0; out_ready = 1'b0;

        // 1: reset, then lookups refused while EMPTY
        tick(); tick();
        chk_en = 1'b1;
        rst = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t1_in_ready", in_ready, 1'b0);
            check("t1_out_valid", out_valid, 1'b0);
            check("t1_M1", M1, 2'b00);
        end
        in_valid = 1'b0;

        // 2: full load with data = addr[1:0]
        pulse_start();
        for (int i = 0; i < 256; i++) begin
            cfg_valid = 1'b1;
            cfg_data  = 2'(i);
            if (i == 255) check("t2_done_early", cfg_done, 1'b0);
            tick();
        end
        cfg_valid = 1'b0;
        check("t2_cfg_done", cfg_done, 1'b1);
        lookup(8'hC5, 2'b01, "t2_C5");
        lookup(8'h02, 2'b10, "t2_02");
        lookup(8'hFF, 2'b11, "t2_FF");

        // 3: backpressure holds the result
        out_ready = 1'b1;
        tick();
        M0 = 8'h03; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        M0 = 8'h10;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t3_M1_held", M1, 2'b11);
            check("t3_in_ready", in_ready, 1'b0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("t3_in_ready_release", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        check("t3_next_M1", M1, 2'b00);

        // 4: partial load abandoned, then a full table of 2'b10
        pulse_start();
        for (int i = 0; i < 100; i++) begin
            cfg_valid = 1'b1;
            cfg_data  = 2'($urandom);
            tick();
        end
        cfg_data = 2'b01;
        pulse_start();
        for (int i = 0; i < 256; i++) begin
            cfg_valid = 1'b1;
            cfg_data  = 2'b10;
            tick();
        end
        cfg_valid = 1'b0;
        for (int i = 0; i < 256; i++) begin
            lookup(8'(i), 2'b10, "t4_all");
        end

        // 5: stray config word while armed
        cfg_valid = 1'b1; cfg_data = 2'b01;
        tick();
        cfg_valid = 1'b0;
        check("t5_cfg_err", cfg_err, 1'b1);
        lookup(8'h00, 2'b10, "t5_tbl0");
        lookup(8'h01, 2'b10, "t5_tbl1");
        check("t5_err_sticky", cfg_err, 1'b1);
        pulse_start();
        check("t5_err_clear", cfg_err, 1'b0);

        // 6: reset during word 40 of a load
        for (int i = 0; i < 40; i++) begin
            cfg_valid = 1'b1;
            cfg_data  = 2'($urandom);
            tick();
        end
        rst = 1'b0;
        tick();
        cfg_valid = 1'b0;
        check("t6_cfg_ready", cfg_ready, 1'b0);
        check("t6_cfg_done", cfg_done, 1'b0);
        check("t6_cfg_err", cfg_err, 1'b0);
        check("t6_in_ready", in_ready, 1'b0);
        check("t6_out_valid", out_valid, 1'b0);
        check("t6_M1", M1, 2'b00);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t6_done_low", cfg_done, 1'b0);
        end

        // Randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            rst       = ($urandom_range(0, 1999) != 0);
            cfg_start = (c == 0) || ($urandom_range(0, 499) == 0);
            cfg_valid = ($urandom_range(0, 9) < 8);
            cfg_data  = 2'($urandom);
            in_valid  = $urandom_range(0, 1) != 0;
            M0        = 8'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            tick();
        end

        rst = 1'b1; cfg_start = 1'b0; cfg_valid = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick(); tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
